ls283_serial_add_ctl: RTL and testbench

Nibble-serial adder/subtractor controller that time-shares one external 4-bit full adder (sn74ls283) between two requesters. It arbitrates requests round-robin and latches the winner's operands. It then steps the adder one nibble per clock, carrying between nibbles through an internal flip-flop, and returns a W-bit result with carry and signed overflow. It sits between the requesting datapaths and a single sn74ls283 instance wired directly to its adder-side ports.

---
 rtl/rr_arb2.sv | 39 +++
 rtl/ls283_serial_add_ctl.sv | 224 ++++++++++++++++++++++
 tb/tb_ls283_serial_add_ctl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
// Grant is combinational from req; the last-winner flop flips the
// preference only when the controller accepts a request (adv).
module rr_arb2 (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // last_q = index of the most recent winner; reset value 1 makes
  // requester 0 the preferred one after reset.
  logic last_q, last_d;

  // One-hot grant: single requester always wins, contention goes to the
  // requester that did not win last time.
  always_comb begin
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner only when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (adv && (gnt != 2'b00)) last_d = gnt[1];
  end

  // Last-winner register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/ls283_serial_add_ctl.sv
// Nibble-serial add/subtract controller sharing one external 4-bit
// ripple adder (sn74ls283) between two requesters. One nibble is
// processed per clock; the inter-nibble carry lives in the add_c0
// register, so nothing ripples combinationally across nibbles.
module ls283_serial_add_ctl #(
  parameter  int NIBBLES = 4,
  parameter  int tCQ     = 1,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [1:0]   req,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         sub0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         sub1,
  output logic [1:0]   gnt,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_c0,
  input  logic [3:0]   add_sum,
  input  logic         add_c4
);

  // Operand width is limited by the 3-bit nibble counter. tCQ describes
  // the board-level clock-to-output delay; the RTL itself adds none.
  localparam bit NIB_OK = (NIBBLES >= 1) && (NIBBLES <= 8);

  if (!NIB_OK || (tCQ < 0)) begin : g_param_chk
    $error("ls283_serial_add_ctl: NIBBLES must be 1..8 and tCQ non-negative");
  end

  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           done_q, done_d;
  logic           done_id_q, done_id_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic [3:0]     add_a_q, add_a_d;
  logic [3:0]     add_b_q, add_b_d;
  logic           add_c0_q, add_c0_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;   // already conditionally inverted (B')
  logic           owner_q, owner_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W-1:0]   acc_q, acc_d;   // partial sum, kept off result until done

  logic [1:0]     arb_gnt;
  logic           arb_adv;
  logic           sel;
  logic           sub_sel;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic [W-1:0]   acc_nxt;
  logic [2:0]     cnt_inc;

  // Extract nibble idx of v.
  function automatic logic [3:0] nib_sel(input logic [W-1:0] v, input logic [2:0] idx);
    logic [W-1:0] t;
    t = v >> {idx, 2'b00};
    return t[3:0];
  endfunction

  // Replace nibble idx of v with n.
  function automatic logic [W-1:0] nib_ins(input logic [W-1:0] v, input logic [2:0] idx,
                                           input logic [3:0] n);
    logic [W-1:0] m;
    logic [W-1:0] d;
    m = W'(4'hF) << {idx, 2'b00};
    d = W'(n)    << {idx, 2'b00};
    return (v & ~m) | d;
  endfunction

  rr_arb2 u_arb (
    .clk   (clk),
    .clr_n (clr_n),
    .req   (req),
    .adv   (arb_adv),
    .gnt   (arb_gnt)
  );

  // Requests are only taken in IDLE; the arbiter pointer moves with them.
  assign arb_adv = (state_q == S_IDLE);

  // Winner operand mux; subtraction is A + ~B + 1 with the +1 on add_c0.
  assign sel     = arb_gnt[1];
  assign sub_sel = sel ? sub1 : sub0;
  assign a_sel   = sel ? a1 : a0;
  assign b_sel   = (sel ? b1 : b0) ^ {W{sub_sel}};
  assign acc_nxt = nib_ins(acc_q, cnt_q, add_sum);
  assign cnt_inc = cnt_q + 3'd1;

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on any request, RUN for NIBBLES
  // samples, one DONE cycle during which requests are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req != 2'b00) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. Adder-side outputs default to 0 so
  // they are quiet in IDLE and DONE.
  always_comb begin
    gnt_d     = 2'b00;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    add_a_d   = 4'h0;
    add_b_d   = 4'h0;
    add_c0_d  = 1'b0;
    opa_d     = opa_q;
    opb_d     = opb_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          gnt_d    = arb_gnt;
          owner_d  = sel;
          opa_d    = a_sel;
          opb_d    = b_sel;
          add_a_d  = a_sel[3:0];
          add_b_d  = b_sel[3:0];
          add_c0_d = sub_sel;
          cnt_d    = 3'd0;
          acc_d    = '0;
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        if (cnt_q != LAST) begin
          cnt_d    = cnt_inc;
          add_a_d  = nib_sel(opa_q, cnt_inc);
          add_b_d  = nib_sel(opb_q, cnt_inc);
          add_c0_d = add_c4;
        end else begin
          result_d  = acc_nxt;
          cout_d    = add_c4;
          // Same-sign operands producing an opposite-sign sum.
          ovf_d     = (opa_q[W-1] == opb_q[W-1]) && (add_sum[3] != opa_q[W-1]);
          done_d    = 1'b1;
          done_id_d = owner_q;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and operation context; reset discards any
  // operation in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      gnt_q     <= 2'b00;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      add_a_q   <= 4'h0;
      add_b_q   <= 4'h0;
      add_c0_q  <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      owner_q   <= 1'b0;
      cnt_q     <= 3'd0;
      acc_q     <= '0;
    end else begin
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_c0_q  <= add_c0_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_c0  = add_c0_q;

endmodule

// File: tb/tb_ls283_serial_add_ctl.sv
// Bench for ls283_serial_add_ctl: controller plus a behavioural
// sn74ls283 at its 24 ns max sum delay, clocked at the 40 ns minimum period.
module tb_ls283_serial_add_ctl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk   = 1'b0;
  logic         clr_n = 1'b0;
  logic [1:0]   req   = 2'b00;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         sub0 = 1'b0, sub1 = 1'b0;
  logic [1:0]   gnt;
  logic         done, done_id, cout, ovf;
  logic [W-1:0] result;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_c0, add_c4;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #20 clk = ~clk;

  // External 4-bit full adder, max-corner propagation delay.
  assign #24 {add_c4, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_c0};

  ls283_serial_add_ctl #(.NIBBLES(NIB), .tCQ(1)) dut (
    .clk(clk), .clr_n(clr_n), .req(req),
    .a0(a0), .b0(b0), .sub0(sub0), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt(gnt), .done(done), .done_id(done_id), .result(result),
    .cout(cout), .ovf(ovf), .add_a(add_a), .add_b(add_b), .add_c0(add_c0),
    .add_sum(add_sum), .add_c4(add_c4)
  );

  // Raise one request with operands, wait (bounded) for its grant, drop req.
  task automatic start_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, output logic [1:0] g, output int wt);
    @(negedge clk);
    if (id == 0) begin a0 = a; b0 = b; sub0 = sub; req = 2'b01; end
    else         begin a1 = a; b1 = b; sub1 = sub; req = 2'b10; end
    g = 2'b00;
    wt = 0;
    while (wt < 20) begin
      @(negedge clk);
      wt++;
      if (gnt !== 2'b00) begin g = gnt; break; end
    end
    req = 2'b00;
  endtask

  // Wait (bounded) for done; n = negedges after the grant negedge.
  task automatic wait_done(output int n, output logic [W-1:0] r, output logic c,
                           output logic o, output logic id);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
    end
    r = result; c = cout; o = ovf; id = done_id;
  endtask

  task automatic test_reset;
    #5;
    cmp_cnt++;
    if ({gnt, done, done_id, result, cout, ovf, add_a, add_b, add_c0} !== '0) begin
      err_cnt++;
      $display("FAIL reset_state: gnt=%b done=%b id=%b result=%h cout=%b ovf=%b a=%h b=%h c0=%b, all must be 0",
               gnt, done, done_id, result, cout, ovf, add_a, add_b, add_c0);
    end
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if ({gnt, done, add_a, add_b, add_c0} !== '0) begin
      err_cnt++;
      $display("FAIL idle_quiet: gnt=%b done=%b a=%h b=%h c0=%b, required 0", gnt, done, add_a, add_b, add_c0);
    end
  endtask

  // Run one operation and compare grant, latency and result fields.
  task automatic test_op(input string nm, input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub, input logic [W-1:0] er,
                         input logic ec, input logic eo);
    logic [1:0] g; int wt, n; logic [W-1:0] r; logic c, o, did;
    logic [1:0] eg;
    eg = (id == 0) ? 2'b01 : 2'b10;
    start_op(id, a, b, sub, g, wt);
    cmp_cnt++;
    if (g !== eg) begin
      err_cnt++;
      $display("FAIL %s gnt: got %b want %b", nm, g, eg);
    end
    wait_done(n, r, c, o, did);
    cmp_cnt++;
    if (n !== NIB) begin
      err_cnt++;
      $display("FAIL %s latency: done %0d cycles after gnt, want %0d", nm, n, NIB);
    end
    cmp_cnt++;
    if ({r, c, o, did} !== {er, ec, eo, (id == 1)}) begin
      err_cnt++;
      $display("FAIL %s result: got r=%h c=%b o=%b id=%b want r=%h c=%b o=%b id=%0d",
               nm, r, c, o, did, er, ec, eo, id);
    end
  endtask

  task automatic test_add_basic;
    test_op("add_basic", 0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
  endtask

  task automatic test_carry_chain;
    test_op("carry_chain", 1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    test_op("sub_ovf", 0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_op("add_ovf", 0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_op("sub_borrow", 1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
  endtask

  // Reset in the middle of RUN: outputs clear at once, no done, pointer back to 0.
  task automatic test_abort;
    logic [1:0] g; int wt, n, pulses; logic [W-1:0] r; logic c, o, did;
    start_op(0, 16'h1234, 16'h4321, 1'b0, g, wt);
    @(posedge clk);
    @(posedge clk);
    #5;
    clr_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({gnt, done, done_id, result, cout, ovf, add_a, add_b, add_c0} !== '0) begin
      err_cnt++;
      $display("FAIL abort_clear: gnt=%b done=%b id=%b result=%h cout=%b ovf=%b a=%h b=%h c0=%b, all must be 0",
               gnt, done, done_id, result, cout, ovf, add_a, add_b, add_c0);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) clr_n = 1'b1;
      if (done !== 1'b0 || gnt !== 2'b00) pulses++;
    end
    cmp_cnt++;
    if (pulses !== 0) begin
      err_cnt++;
      $display("FAIL abort_no_done: %0d cycles with done/gnt active, want 0", pulses);
    end
    a0 = 16'h1234; b0 = 16'h4321; sub0 = 1'b0;
    a1 = 16'hFFFF; b1 = 16'h0001; sub1 = 1'b0;
    req = 2'b11;
    g = 2'b00;
    wt = 0;
    while (wt < 20) begin
      @(negedge clk);
      wt++;
      if (gnt !== 2'b00) begin g = gnt; break; end
    end
    req = 2'b00;
    cmp_cnt++;
    if (g !== 2'b01) begin
      err_cnt++;
      $display("FAIL abort_pointer: gnt=%b want 01", g);
    end
    wait_done(n, r, c, o, did);
    cmp_cnt++;
    if ({r, did} !== {16'h5555, 1'b0}) begin
      err_cnt++;
      $display("FAIL abort_rerun: result=%h id=%b want 5555 id 0", r, did);
    end
  endtask

  // Both requests held from reset: strict alternation every NIB+2 cycles.
  task automatic test_back_to_back;
    logic [1:0]   gv[4];
    int           gcyc[4];
    logic         did[4];
    logic [W-1:0] rv[4];
    int ng, nd;
    for (int i = 0; i < 4; i++) begin gv[i] = '0; gcyc[i] = 0; did[i] = 1'bx; rv[i] = 'x; end
    clr_n = 1'b0;
    a0 = 16'h1234; b0 = 16'h4321; sub0 = 1'b0;
    a1 = 16'hFFFF; b1 = 16'h0001; sub1 = 1'b0;
    req = 2'b11;
    @(negedge clk);
    clr_n = 1'b1;
    ng = 0;
    nd = 0;
    for (int cyc = 0; cyc < 40 && nd < 4; cyc++) begin
      @(negedge clk);
      if (gnt !== 2'b00 && ng < 4) begin gv[ng] = gnt; gcyc[ng] = cyc; ng++; end
      if (done === 1'b1 && nd < 4) begin did[nd] = done_id; rv[nd] = result; nd++; end
    end
    req = 2'b00;
    cmp_cnt++;
    if (ng !== 4 || nd !== 4) begin
      err_cnt++;
      $display("FAIL b2b_count: grants=%0d dones=%0d want 4/4", ng, nd);
    end
    for (int i = 0; i < 4; i++) begin
      cmp_cnt++;
      if ({gv[i], did[i], rv[i]} !== {((i % 2) ? 2'b10 : 2'b01), (i % 2 == 1),
                                       ((i % 2) ? 16'h0000 : 16'h5555)}) begin
        err_cnt++;
        $display("FAIL b2b_op%0d: gnt=%b id=%b result=%h want gnt=%b id=%0d result=%h", i,
                 gv[i], did[i], rv[i], (i % 2) ? 2'b10 : 2'b01, i % 2, (i % 2) ? 16'h0000 : 16'h5555);
      end
      if (i > 0) begin
        cmp_cnt++;
        if (gcyc[i] - gcyc[i-1] !== NIB + 2) begin
          err_cnt++;
          $display("FAIL b2b_spacing%0d: %0d cycles between grants, want %0d", i,
                   gcyc[i] - gcyc[i-1], NIB + 2);
        end
      end
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_chain();
    test_overflow();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
